// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, EX-stage learning and stats.
// Latency: prediction is combinational from fetch_pc; updates become visible the cycle after resolution.
// Backpressure: none; one prediction and one resolution per cycle, mispredict is a same-cycle flush request.
module branch_predictor_btb #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic              res_is_jump,
    input  logic              res_taken,
    input  logic [31:0]       res_target,
    input  logic              res_pred_taken,
    input  logic [31:0]       res_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic [31:0]      fetch_pc_ext, res_pc_ext;
    logic             r_hit, eff_taken;
    btb_entry_t       upd;
    logic             upd_en;

    assign f_idx        = fetch_pc[IDX_W+1:2];
    assign f_tag        = fetch_pc[PC_W-1:IDX_W+2];
    assign r_idx        = res_pc[IDX_W+1:2];
    assign r_tag        = res_pc[PC_W-1:IDX_W+2];
    assign fetch_pc_ext = 32'(fetch_pc);
    assign res_pc_ext   = 32'(res_pc);

    // Prediction reads the array directly, so a same-cycle update is seen only next cycle.
    assign pred_hit    = btb[f_idx].vld && (btb[f_idx].tag == f_tag);
    assign pred_taken  = pred_hit && btb[f_idx].ctr[CTR_W-1];
    assign pred_target = pred_taken ? btb[f_idx].target : fetch_pc_ext + 32'd4;

    assign eff_taken   = res_is_jump | res_taken;
    assign mispredict  = res_valid &
                         ((eff_taken != res_pred_taken) |
                          (eff_taken & res_pred_taken & (res_target != res_pred_target)));
    assign redirect_pc = eff_taken ? res_target : res_pc_ext + 32'd4;

    assign r_hit = btb[r_idx].vld && (btb[r_idx].tag == r_tag);

    always_comb begin
        upd    = btb[r_idx];
        upd_en = 1'b0;
        if (res_valid) begin
            if (r_hit) begin
                upd_en = 1'b1;
                if (res_is_jump)
                    upd.ctr = CTR_MAX;
                else if (res_taken)
                    upd.ctr = (btb[r_idx].ctr == CTR_MAX) ? CTR_MAX : btb[r_idx].ctr + CTR_W'(1);
                else
                    upd.ctr = (btb[r_idx].ctr == '0) ? '0 : btb[r_idx].ctr - CTR_W'(1);
                if (eff_taken)
                    upd.target = res_target;
            end else if (eff_taken) begin
                // Miss on a taken branch: allocate, evicting whatever aliases at this index.
                upd_en     = 1'b1;
                upd.vld    = 1'b1;
                upd.tag    = r_tag;
                upd.target = res_target;
                upd.ctr    = res_is_jump ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].vld    <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= '0;
                btb[i].ctr    <= CTR_WNT;
            end
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_en)
                btb[r_idx] <= upd;
            if (res_valid && (stat_branches != '1))
                stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict && (stat_mispred != '1))
                stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: per-cycle vector table plus reset and stat-saturation sequences.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  fetch_pc;
    logic        res_valid;
    logic [8:0]  res_pc;
    logic        res_is_jump;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc;
    logic [15:0] stat_branches, stat_mispred;

    logic        s_hit, s_taken, s_mp;
    logic [31:0] s_target, s_redir;
    logic [3:0]  s_sb, s_sm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.PC_W(9), .ENTRIES(16), .CTR_W(2), .STAT_W(16)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_predictor_btb #(.PC_W(9), .ENTRIES(16), .CTR_W(2), .STAT_W(4)) dut_s (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_jump(res_is_jump),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(s_mp), .redirect_pc(s_redir),
        .stat_branches(s_sb), .stat_mispred(s_sm)
    );

    typedef struct {
        logic [8:0]  fpc;
        logic        rv;
        logic [8:0]  rpc;
        logic        rj;
        logic        rt;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic        e_mp;
        logic [31:0] e_redir;
        logic [15:0] e_sb;
        logic [15:0] e_sm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [8:0] fpc, input logic rv, input logic [8:0] rpc,
                                input logic rj, input logic rt, input logic [31:0] rtgt,
                                input logic rpt, input logic [31:0] rptgt,
                                input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                                input logic e_mp, input logic [31:0] e_redir,
                                input logic [15:0] e_sb, input logic [15:0] e_sm);
        vec_t v;
        v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rj = rj; v.rt = rt; v.rtgt = rtgt;
        v.rpt = rpt; v.rptgt = rptgt; v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt;
        v.e_mp = e_mp; v.e_redir = e_redir; v.e_sb = e_sb; v.e_sm = e_sm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] fpc, input logic rv, input logic [8:0] rpc,
                         input logic rj, input logic rt, input logic [31:0] rtgt,
                         input logic rpt, input logic [31:0] rptgt);
        fetch_pc = fpc; res_valid = rv; res_pc = rpc; res_is_jump = rj;
        res_taken = rt; res_target = rtgt; res_pred_taken = rpt; res_pred_target = rptgt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(9'h040, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // fpc rv rpc rj rt rtgt rpt rptgt | hit tk tgt mp redir sb sm (stats before the edge)
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          0,0,32'h44,0,32'h4,0,0));
        vecs.push_back(mk(9'h040,1,9'h040,0,1,32'h100,0,32'h44,       0,0,32'h44,1,32'h100,0,0));
        vecs.push_back(mk(9'h040,1,9'h040,0,0,32'h100,1,32'h100,      1,1,32'h100,1,32'h44,1,1));
        vecs.push_back(mk(9'h040,1,9'h040,0,0,32'h100,0,32'h44,       1,0,32'h44,0,32'h44,2,2));
        vecs.push_back(mk(9'h040,1,9'h040,0,0,32'h100,0,32'h44,       1,0,32'h44,0,32'h44,3,2));
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          1,0,32'h44,0,32'h4,4,2));
        vecs.push_back(mk(9'h040,1,9'h040,0,1,32'h104,0,32'h44,       1,0,32'h44,1,32'h104,4,2));
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          1,0,32'h44,0,32'h4,5,3));
        vecs.push_back(mk(9'h040,1,9'h040,0,1,32'h104,0,32'h44,       1,0,32'h44,1,32'h104,5,3));
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          1,1,32'h104,0,32'h4,6,4));
        vecs.push_back(mk(9'h040,1,9'h040,0,1,32'h108,1,32'h104,      1,1,32'h104,1,32'h108,6,4));
        vecs.push_back(mk(9'h040,1,9'h040,0,1,32'h108,1,32'h108,      1,1,32'h108,0,32'h108,7,5));
        vecs.push_back(mk(9'h040,1,9'h040,0,0,32'h108,1,32'h108,      1,1,32'h108,1,32'h44,8,5));
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          1,1,32'h108,0,32'h4,9,6));
        vecs.push_back(mk(9'h080,1,9'h080,1,0,32'h20,0,32'h84,        0,0,32'h84,1,32'h20,9,6));
        vecs.push_back(mk(9'h040,0,9'h000,0,0,32'h0,0,32'h0,          0,0,32'h44,0,32'h4,10,7));
        vecs.push_back(mk(9'h080,1,9'h080,1,0,32'h20,1,32'h20,        1,1,32'h20,0,32'h20,10,7));
        vecs.push_back(mk(9'h0C0,1,9'h0C0,0,1,32'h10,0,32'hC4,        0,0,32'hC4,1,32'h10,11,7));
        vecs.push_back(mk(9'h080,0,9'h000,0,0,32'h0,0,32'h0,          0,0,32'h84,0,32'h4,12,8));
        vecs.push_back(mk(9'h0C0,0,9'h000,0,0,32'h0,0,32'h0,          1,1,32'h10,0,32'h4,12,8));
        vecs.push_back(mk(9'h0C0,1,9'h0C0,0,0,32'h10,1,32'h10,        1,1,32'h10,1,32'hC4,12,8));
        vecs.push_back(mk(9'h0C0,0,9'h000,0,0,32'h0,0,32'h0,          1,0,32'hC4,0,32'h4,13,9));
        vecs.push_back(mk(9'h044,1,9'h044,0,0,32'h0,0,32'h48,         0,0,32'h48,0,32'h48,13,9));
        vecs.push_back(mk(9'h044,0,9'h000,0,0,32'h0,0,32'h0,          0,0,32'h48,0,32'h4,14,9));
        vecs.push_back(mk(9'h0C3,0,9'h000,0,0,32'h0,0,32'h0,          1,0,32'hC7,0,32'h4,14,9));
        vecs.push_back(mk(9'h1FC,1,9'h1FC,1,0,32'hABCD0000,0,32'h200, 0,0,32'h200,1,32'hABCD0000,14,9));
        vecs.push_back(mk(9'h1FC,0,9'h000,0,0,32'h0,0,32'h0,          1,1,32'hABCD0000,0,32'h4,15,10));

        cyc();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fpc, vecs[i].rv, vecs[i].rpc, vecs[i].rj, vecs[i].rt,
                  vecs[i].rtgt, vecs[i].rpt, vecs[i].rptgt);
            #2;
            chk($sformatf("v%0d pred_hit", i),      32'(pred_hit),      32'(vecs[i].e_hit));
            chk($sformatf("v%0d pred_taken", i),    32'(pred_taken),    32'(vecs[i].e_tk));
            chk($sformatf("v%0d pred_target", i),   pred_target,        vecs[i].e_tgt);
            chk($sformatf("v%0d mispredict", i),    32'(mispredict),    32'(vecs[i].e_mp));
            chk($sformatf("v%0d redirect_pc", i),   redirect_pc,        vecs[i].e_redir);
            chk($sformatf("v%0d stat_branches", i), 32'(stat_branches), 32'(vecs[i].e_sb));
            chk($sformatf("v%0d stat_mispred", i),  32'(stat_mispred),  32'(vecs[i].e_sm));
            chk($sformatf("v%0d s_hit", i),         32'(s_hit),         32'(vecs[i].e_hit));
            chk($sformatf("v%0d s_target", i),      s_target,           vecs[i].e_tgt);
            chk($sformatf("v%0d s_mispredict", i),  32'(s_mp),          32'(vecs[i].e_mp));
            chk($sformatf("v%0d s_redirect", i),    s_redir,            vecs[i].e_redir);
            chk($sformatf("v%0d s_stat_branches", i), 32'(s_sb),        32'(vecs[i].e_sb));
            chk($sformatf("v%0d s_stat_mispred", i),  32'(s_sm),        32'(vecs[i].e_sm));
            cyc();
        end

        // Mid-run reset with a resolution present: everything learned is dropped, the resolve too.
        reset = 1'b1;
        drive(9'h040, 1'b1, 9'h040, 1'b0, 1'b1, 32'h300, 1'b0, 32'h44);
        cyc();
        reset = 1'b0;
        drive(9'h1FC, 1'b0, 9'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("rst hit 1FC", 32'(pred_hit), 32'h0);
        chk("rst target 1FC", pred_target, 32'h200);
        fetch_pc = 9'h0C0;
        #1;
        chk("rst hit 0C0", 32'(pred_hit), 32'h0);
        fetch_pc = 9'h040;
        #1;
        chk("rst hit 040", 32'(pred_hit), 32'h0);
        chk("rst taken 040", 32'(pred_taken), 32'h0);
        chk("rst target 040", pred_target, 32'h44);
        chk("rst stat_branches", 32'(stat_branches), 32'h0);
        chk("rst stat_mispred", 32'(stat_mispred), 32'h0);
        chk("rst s_stat_branches", 32'(s_sb), 32'h0);
        cyc();

        // 17 mispredicting resolves: the 4-bit stats must pin at 0xF instead of wrapping.
        drive(9'h100, 1'b1, 9'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104);
        for (int n = 0; n < 17; n++) begin
            #1;
            chk($sformatf("sat%0d mispredict", n), 32'(mispredict), 32'h1);
            if (n == 14) begin
                chk("sat14 s_stat_branches", 32'(s_sb), 32'hE);
                chk("sat14 s_stat_mispred", 32'(s_sm), 32'hE);
            end
            cyc();
        end
        res_valid = 1'b0;
        #1;
        chk("sat s_stat_branches", 32'(s_sb), 32'hF);
        chk("sat s_stat_mispred", 32'(s_sm), 32'hF);
        chk("sat stat_branches", 32'(stat_branches), 32'd17);
        chk("sat stat_mispred", 32'(stat_mispred), 32'd17);
        fetch_pc = 9'h100;
        #1;
        chk("sat hit 100", 32'(pred_hit), 32'h1);
        chk("sat target 100", pred_target, 32'h200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
